// File: rtl/mig_ui_responder.sv
// Memory-side stand-in for the MIG UI: command/write-data queues, 128-bit word RAM, fixed-latency
// in-order reads. Optional periodic refresh stalls are built when MIG_REFRESH_STALL_EN is defined.
module mig_ui_responder #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned CMD_DEPTH      = 8,
  parameter int unsigned WDF_DEPTH      = 4,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned CALIB_CYCLES   = 16,
  parameter int unsigned REFRESH_PERIOD = 256,
  parameter int unsigned REFRESH_STALL  = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [26:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic         app_sr_active,
  output logic         app_ref_ack,
  output logic         app_zq_ack,
  output logic         cmd_err
);

  localparam int unsigned CPW   = $clog2(CMD_DEPTH);
  localparam int unsigned WPW   = $clog2(WDF_DEPTH);
  localparam int unsigned CALW  = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [CALW-1:0]   calib_cnt_q;
  logic              stalled;
  logic              cmd_legal, cmd_push, cmd_pop, wdf_push;
  logic              head_valid, head_rd, exec_rd, exec_wr;
  logic [ADDR_W-1:0] head_idx;

  logic              cmd_rd_mem  [CMD_DEPTH];
  logic [ADDR_W-1:0] cmd_idx_mem [CMD_DEPTH];
  logic [CPW-1:0]    cmd_wp_q, cmd_rp_q;
  logic [CPW:0]      cmd_cnt_q;

  logic [127:0]      wdf_data_mem [WDF_DEPTH];
  logic [15:0]       wdf_mask_mem [WDF_DEPTH];
  logic [WPW-1:0]    wdf_wp_q, wdf_rp_q;
  logic [WPW:0]      wdf_cnt_q;
  logic [127:0]      wdf_head_data;
  logic [15:0]       wdf_head_mask;

  logic [127:0]      mem [WORDS];
  logic              rd_issue_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [127:0]      pipe_data_q [RD_LATENCY];
  logic              cmd_err_q;

  logic unused_inputs;
  assign unused_inputs = ^{app_wdf_end, app_addr[26:ADDR_W+3], app_addr[2:0]};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      calib_cnt_q <= '0;
    end else if (!init_calib_complete) begin
      calib_cnt_q <= calib_cnt_q + 1'b1;
    end
  end

  assign init_calib_complete = (calib_cnt_q == CALW'(CALIB_CYCLES));

`ifdef MIG_REFRESH_STALL_EN
  localparam int unsigned RFW = $clog2(REFRESH_PERIOD);
  logic [RFW-1:0] ref_cnt_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ref_cnt_q <= '0;
    end else if (init_calib_complete) begin
      ref_cnt_q <= (ref_cnt_q == RFW'(REFRESH_PERIOD - 1)) ? '0 : ref_cnt_q + 1'b1;
    end
  end

  // The last REFRESH_STALL counts of each period are the refresh window.
  assign stalled = init_calib_complete && (ref_cnt_q >= RFW'(REFRESH_PERIOD - REFRESH_STALL));
`else
  assign stalled = 1'b0;
`endif

  assign app_rdy     = init_calib_complete && (cmd_cnt_q != (CPW+1)'(CMD_DEPTH)) && !stalled;
  assign app_wdf_rdy = init_calib_complete && (wdf_cnt_q != (WPW+1)'(WDF_DEPTH)) && !stalled;

  assign cmd_legal = (app_cmd == 3'b000) || (app_cmd == 3'b001);
  assign cmd_push  = app_en && app_rdy && cmd_legal;
  assign wdf_push  = app_wdf_wren && app_wdf_rdy;

  assign head_valid    = (cmd_cnt_q != '0);
  assign head_rd       = cmd_rd_mem[cmd_rp_q];
  assign head_idx      = cmd_idx_mem[cmd_rp_q];
  assign wdf_head_data = wdf_data_mem[wdf_rp_q];
  assign wdf_head_mask = wdf_mask_mem[wdf_rp_q];

  // A write at the head with no data blocks everything behind it.
  assign exec_rd = head_valid && !stalled && head_rd;
  assign exec_wr = head_valid && !stalled && !head_rd && (wdf_cnt_q != '0);
  assign cmd_pop = exec_rd || exec_wr;

  always_ff @(posedge clk_in) begin
    if (cmd_push) begin
      cmd_rd_mem[cmd_wp_q]  <= app_cmd[0];
      cmd_idx_mem[cmd_wp_q] <= app_addr[ADDR_W+2:3];
    end
    if (wdf_push) begin
      wdf_data_mem[wdf_wp_q] <= app_wdf_data;
      wdf_mask_mem[wdf_wp_q] <= app_wdf_mask;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
        2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
        default: cmd_cnt_q <= cmd_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wdf_wp_q  <= '0;
      wdf_rp_q  <= '0;
      wdf_cnt_q <= '0;
    end else begin
      if (wdf_push) wdf_wp_q <= wdf_wp_q + 1'b1;
      if (exec_wr)  wdf_rp_q <= wdf_rp_q + 1'b1;
      case ({wdf_push, exec_wr})
        2'b10:   wdf_cnt_q <= wdf_cnt_q + 1'b1;
        2'b01:   wdf_cnt_q <= wdf_cnt_q - 1'b1;
        default: wdf_cnt_q <= wdf_cnt_q;
      endcase
    end
  end

  // RAM is never cleared; a reset edge must not let a pending write land.
  always_ff @(posedge clk_in) begin
    if (rst_in && exec_wr) begin
      for (int b = 0; b < 16; b++) begin
        if (!wdf_head_mask[b]) mem[head_idx][8*b +: 8] <= wdf_head_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_issue_q <= 1'b0;
      rd_idx_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      rd_issue_q     <= exec_rd;
      rd_idx_q       <= head_idx;
      pipe_vld_q[0]  <= rd_issue_q;
      pipe_data_q[0] <= mem[rd_idx_q];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cmd_err_q <= 1'b0;
    end else if (app_en && app_rdy && !cmd_legal) begin
      cmd_err_q <= 1'b1;
    end
  end

  assign app_rd_data       = pipe_data_q[RD_LATENCY-1];
  assign app_rd_data_valid = pipe_vld_q[RD_LATENCY-1];
  assign app_rd_data_end   = pipe_vld_q[RD_LATENCY-1];
  assign cmd_err           = cmd_err_q;
  assign app_sr_active     = 1'b0;
  assign app_ref_ack       = 1'b0;
  assign app_zq_ack        = 1'b0;

endmodule
